clock_domain_crossing: RTL and testbench

CLOCK_DOMAIN_CROSSING -- requirements
Module: clock_domain_crossing

---
 rtl/cdc_pkg.sv | 11 +
 rtl/sync_2ff.sv | 21 ++
 rtl/clock_domain_crossing.sv | 90 +++++++++
 tb/tb_clock_domain_crossing.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake clock domain crossing.
package cdc_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } src_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-stage synchronizer; resets both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_domain_crossing.sv
// One-word-in-flight payload crossing using req/ack toggles; the payload bus
// itself is never synchronized, only sampled once its toggle has crossed.
module clock_domain_crossing
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_src,
  input  logic                  clk_dst,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_src,
  input  logic                  valid_src,
  output logic                  ready_src,
  output logic [DATA_WIDTH-1:0] data_dst,
  output logic                  valid_dst,
  input  logic                  ready_dst
);

  src_state_t            state;
  src_state_t            state_nxt;
  logic                  req_tog;
  logic [DATA_WIDTH-1:0] hold;
  logic                  ack_sync;
  logic                  accept;

  logic                  ack_tog;
  logic                  req_sync;
  logic                  req_seen;

  // source domain
  assign accept = (state == IDLE) && valid_src;

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_tog <= 1'b0;
      hold    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hold    <= data_src;
        req_tog <= ~req_tog;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready_src = (state == IDLE);
    case (state)
      IDLE: if (valid_src) state_nxt = BUSY;
      BUSY: if (ack_sync == req_tog) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  sync_2ff u_ack_sync (
    .clk   (clk_src),
    .rst_n (rst_n),
    .d     (ack_tog),
    .q     (ack_sync)
  );

  // destination domain; hold is quiet by the time req_sync reflects the toggle
  sync_2ff u_req_sync (
    .clk   (clk_dst),
    .rst_n (rst_n),
    .d     (req_tog),
    .q     (req_sync)
  );

  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      req_seen  <= 1'b0;
      valid_dst <= 1'b0;
      data_dst  <= '0;
      ack_tog   <= 1'b0;
    end else if (valid_dst) begin
      if (ready_dst) begin
        valid_dst <= 1'b0;
        ack_tog   <= ~ack_tog;
      end
    end else if (req_sync != req_seen) begin
      data_dst  <= hold;
      valid_dst <= 1'b1;
      req_seen  <= req_sync;
    end
  end

endmodule

// File: tb/tb_clock_domain_crossing.sv
// Directed/random bench for clock_domain_crossing with a queue-based reference.
`timescale 1ns/1ps
module tb_clock_domain_crossing;

  logic       clk_src = 1'b0;
  logic       clk_dst = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_src = 8'h00;
  logic       valid_src = 1'b0;
  logic       ready_src;
  logic [7:0] data_dst;
  logic       valid_dst;
  logic       ready_dst = 1'b1;

  realtime src_half = 5.0;
  realtime dst_half = 7.5;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int expected_cnt = 0;
  logic [7:0] exp_q[$];

  clock_domain_crossing #(.DATA_WIDTH(8)) dut (
    .clk_src   (clk_src),
    .clk_dst   (clk_dst),
    .rst_n     (rst_n),
    .data_src  (data_src),
    .valid_src (valid_src),
    .ready_src (ready_src),
    .data_dst  (data_dst),
    .valid_dst (valid_dst),
    .ready_dst (ready_dst)
  );

  always #(src_half) clk_src = ~clk_src;
  always #(dst_half) clk_dst = ~clk_dst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // a delivery is a negedge where valid_dst and ready_dst are both high
  always @(negedge clk_dst) begin
    if (rst_n && valid_dst && ready_dst) begin
      chk("dst_word_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("dst_data", data_dst, exp_q.pop_front());
      delivered++;
    end
  end

  task automatic send(input logic [7:0] w, input bit lat);
    int n;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_src);
      if (ready_src) begin ok = 1'b1; break; end
    end
    chk("ready_before_send", ok, 1);
    valid_src = 1'b1;
    data_src  = w;
    @(posedge clk_src); #1;
    valid_src = 1'b0;
    data_src  = 8'($urandom);
    exp_q.push_back(w);
    expected_cnt++;
    chk("ready_low_after_accept", ready_src, 0);
    if (lat) begin
      n = 0;
      while (n < 50) begin
        @(posedge clk_dst); #1;
        n++;
        if (valid_dst) break;
      end
      chk("req_latency", n, 3);
      @(posedge clk_dst); #1;
      chk("valid_single_pulse", valid_dst, 0);
      n = 0;
      while (n < 50) begin
        @(posedge clk_src); #1;
        n++;
        if (ready_src) break;
      end
      chk("ack_latency", n, 3);
      chk("delivered_count", delivered, expected_cnt);
    end
  endtask

  task automatic wait_ready_src(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_src);
      if (ready_src) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    // reset state
    #20;
    chk("rst_ready_src", ready_src, 1);
    chk("rst_valid_dst", valid_dst, 0);
    chk("rst_data_dst", data_dst, 0);
    @(negedge clk_src);
    rst_n = 1'b1;

    // 10..100 in order, src 10 ns / dst 15 ns
    for (int k = 1; k <= 10; k++) send(8'(k * 10), 1'b1);

    // consumer stalls for 4 cycles
    @(posedge clk_dst); #1;
    ready_dst = 1'b0;
    send(8'h55, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_dst);
      if (valid_dst) begin ok = 1'b1; break; end
    end
    chk("stall_valid_seen", ok, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_dst);
      chk("stall_valid_hold", valid_dst, 1);
      chk("stall_data_hold", data_dst, 8'h55);
      chk("stall_ready_src_low", ready_src, 0);
    end
    @(posedge clk_dst); #1;
    ready_dst = 1'b1;
    wait_ready_src("stall_ready_src_returns");
    chk("stall_delivered", delivered, expected_cnt);

    // valid_src held with changing data while BUSY
    wait_ready_src("busy_ready_before");
    valid_src = 1'b1;
    data_src  = 8'hA5;
    @(posedge clk_src); #1;
    exp_q.push_back(8'hA5);
    expected_cnt++;
    chk("busy_accepted", ready_src, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_src);
      if (ready_src) begin ok = 1'b1; break; end
      data_src = 8'($urandom);
    end
    chk("busy_returns_idle", ok, 1);
    valid_src = 1'b0;
    repeat (20) @(posedge clk_dst);
    #1;
    chk("busy_no_duplicate", delivered, expected_cnt);
    chk("busy_queue_empty", exp_q.size(), 0);
    chk("busy_not_reaccepted", ready_src, 1);

    // reset between acceptance and valid_dst
    send(8'h99, 1'b0);
    @(posedge clk_dst); #1;
    rst_n = 1'b0;
    exp_q.delete();
    expected_cnt--;
    #1;
    chk("midrst_valid_dst", valid_dst, 0);
    chk("midrst_ready_src", ready_src, 1);
    repeat (3) @(posedge clk_src);
    @(negedge clk_src);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_dst);
      chk("midrst_no_spurious", valid_dst, 0);
    end
    send(8'h3C, 1'b1);

    // swapped ratio: src 15 ns, dst 10 ns, random words and gaps
    src_half = 7.5;
    dst_half = 5.0;
    repeat (4) @(posedge clk_src);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_src);
      send(8'($urandom), 1'b1);
    end

    repeat (20) @(posedge clk_dst);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_delivered", delivered, expected_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
